// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encodings and source/index widths.
package irq_pkg;

   localparam int MAX_IRQ_SRC = 16;
   localparam int IRQ_IDX_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Bus between the interrupt arbiter, the software mask port and the downstream redirect unit.
interface interrupt_arbiter_if;
   import irq_pkg::*;

   // Handshake: int_signal_n is driven low with a stable int_index and stays that way until
   // taken_n is sampled low on a clock edge; eret_n low (one cycle) closes the service window.
   logic                   int_signal_n;
   logic [IRQ_IDX_W-1:0]   int_index;
   logic                   taken_n;
   logic                   eret_n;
   logic                   mask_we;
   logic [MAX_IRQ_SRC-1:0] mask_wdata;

   modport master (
      output int_signal_n, int_index,
      input  taken_n, eret_n, mask_we, mask_wdata
   );

   modport slave (
      input  int_signal_n, int_index,
      output taken_n, eret_n, mask_we, mask_wdata
   );

endinterface

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser per line plus an edge-history register; emits a 1-cycle rising-edge pulse.
module irq_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] irq_i,
   output logic [WIDTH-1:0] edge_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// Latches synchronised interrupt edges as pending, masks them, and requests the lowest-index
// winner from the downstream unit, holding it until taken and blocking until the handler returns.
module interrupt_arbiter
   import irq_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     irq_raw,
   interrupt_arbiter_if.master    bus,
   output logic [MAX_IRQ_SRC-1:0] mask,
   output logic [NUM_SRC-1:0]     pending,
   output logic                   busy,
   output irq_state_e             dbg_state
);

   logic [NUM_SRC-1:0]   irq_edge;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   mask_q;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   clr;
   logic [IRQ_IDX_W-1:0] winner;
   logic [IRQ_IDX_W-1:0] idx_q, idx_d;
   logic                 sig_n_q, sig_n_d;
   irq_state_e           state_q, state_d;
   logic                 unused_mask_hi;

   irq_sync_edge #(
      .WIDTH       (NUM_SRC),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (irq_raw),
      .edge_o (irq_edge)
   );

   // Bits of the write data above NUM_SRC are deliberately discarded.
   assign unused_mask_hi = ^bus.mask_wdata;

   assign eligible = pending_q & mask_q;

   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = IRQ_IDX_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      sig_n_d = sig_n_q;
      idx_d   = idx_q;
      clr     = '0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_REQ;
               sig_n_d = 1'b0;
               idx_d   = winner;
            end
         end
         ST_REQ: begin
            // Only taken_n matters here; a simultaneous eret_n is dropped.
            if (!bus.taken_n) begin
               state_d = ST_SERVICE;
               sig_n_d = 1'b1;
               for (int i = 0; i < NUM_SRC; i++) begin
                  clr[i] = (idx_q == IRQ_IDX_W'(i));
               end
            end
         end
         ST_SERVICE: begin
            if (!bus.eret_n) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sig_n_d = 1'b1;
         end
      endcase
   end

   // A fresh edge arriving as its source is being cleared survives as a new event.
   assign pending_d = (pending_q & ~clr) | irq_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sig_n_q   <= 1'b1;
         idx_q     <= '0;
         pending_q <= '0;
         mask_q    <= {NUM_SRC{1'b1}};
      end else begin
         state_q   <= state_d;
         sig_n_q   <= sig_n_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         if (bus.mask_we) mask_q <= bus.mask_wdata[NUM_SRC-1:0];
      end
   end

   always_comb begin
      mask                = '0;
      mask[NUM_SRC-1:0]   = mask_q;
   end

   assign bus.int_signal_n = sig_n_q;
   assign bus.int_index    = idx_q;
   assign pending          = pending_q;
   assign busy             = (state_q != ST_IDLE);
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Randomised and directed bench for interrupt_arbiter, checked against an event-level reference model.
module tb_interrupt_arbiter;
   import irq_pkg::*;

   localparam int N    = 8;
   localparam int SYNC = 2;
   localparam int M_IDLE = 0, M_REQ = 1, M_SERVICE = 2;

   logic         clk;
   logic         rst;
   logic [N-1:0] irq_raw;
   logic [15:0]  mask;
   logic [N-1:0] pending;
   logic         busy;
   irq_state_e   dbg_state;

   interrupt_arbiter_if bus();

   interrupt_arbiter #(.NUM_SRC(N), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_raw   (irq_raw),
      .bus       (bus),
      .mask      (mask),
      .pending   (pending),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         n_asserts = 0;
   int         n_fail    = 0;
   int         n_req     = 0;
   logic [3:0] exp_q[$];

   // ---------------- reference model ----------------
   int           m_mode;
   int           m_idx;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_mask;
   logic [N-1:0] raw_prev;
   logic [N-1:0] ev_pipe[$];

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_idx    = 0;
      m_pend   = '0;
      m_mask   = '1;
      raw_prev = '0;
      ev_pipe  = {};
      for (int i = 0; i < SYNC; i++) ev_pipe.push_back('0);
   endtask

   // One clock edge of the architectural behaviour: a raw rise becomes a pending event
   // SYNC edges later, the lowest eligible index is requested, taken clears it, eret reopens.
   task automatic model_step();
      logic [N-1:0] arriving;
      logic [N-1:0] elig;
      logic [N-1:0] clr;
      arriving = ev_pipe.pop_front();
      ev_pipe.push_back(irq_raw & ~raw_prev);
      raw_prev = irq_raw;
      elig = m_pend & m_mask;
      clr  = '0;
      if (m_mode == M_IDLE) begin
         if (elig != 0) begin
            for (int i = 0; i < N; i++) begin
               if (elig[i]) begin
                  m_idx = i;
                  break;
               end
            end
            m_mode = M_REQ;
            exp_q.push_back(4'(m_idx));
         end
      end else if (m_mode == M_REQ) begin
         if (!bus.taken_n) begin
            clr[m_idx] = 1'b1;
            m_mode = M_SERVICE;
         end
      end else begin
         if (!bus.eret_n) m_mode = M_IDLE;
      end
      m_pend = (m_pend & ~clr) | arriving;
      if (bus.mask_we) m_mask = bus.mask_wdata[N-1:0];
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // ---------------- checking ----------------
   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic prev_sig;
   always @(negedge clk) begin
      if (!rst) begin
         prev_sig = 1'b1;
      end else begin
         if (prev_sig && !bus.int_signal_n) begin
            n_req++;
            if (exp_q.size() == 0) begin
               n_asserts++;
               n_fail++;
               $display("FAIL unexpected_request: got index %0d expected no request at %0t",
                        bus.int_index, $time);
            end else begin
               check_val("request_index", 16'(bus.int_index), 16'(exp_q.pop_front()));
            end
         end
         prev_sig = bus.int_signal_n;
         check_val("int_signal_n", 16'(bus.int_signal_n), 16'(m_mode != M_REQ));
         check_val("busy", 16'(busy), 16'(m_mode != M_IDLE));
         check_val("pending", 16'(pending), 16'(m_pend));
         check_val("mask", mask, 16'(m_mask));
         if (m_mode == M_REQ) check_val("held_index", 16'(bus.int_index), 16'(m_idx));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_raw(input int src);
      @(negedge clk) irq_raw[src] = 1'b1;
      @(negedge clk) irq_raw[src] = 1'b0;
   endtask

   task automatic pulse_taken();
      @(negedge clk) bus.taken_n = 1'b0;
      @(negedge clk) bus.taken_n = 1'b1;
   endtask

   task automatic pulse_eret();
      @(negedge clk) bus.eret_n = 1'b0;
      @(negedge clk) bus.eret_n = 1'b1;
   endtask

   task automatic write_mask(input logic [15:0] val);
      @(negedge clk) begin
         bus.mask_we    = 1'b1;
         bus.mask_wdata = val;
      end
      @(negedge clk) bus.mask_we = 1'b0;
   endtask

   task automatic wait_req(input string name, input int exp_idx);
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (!bus.int_signal_n) seen = 1;
      end
      if (!seen) begin
         n_asserts++;
         n_fail++;
         $display("FAIL %s: got no request within 20 cycles expected index %0d", name, exp_idx);
      end else begin
         check_val(name, 16'(bus.int_index), 16'(exp_idx));
      end
   endtask

   task automatic service_one();
      pulse_taken();
      pulse_eret();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int req_before;
      rst            = 1'b0;
      irq_raw        = '0;
      bus.taken_n    = 1'b1;
      bus.eret_n     = 1'b1;
      bus.mask_we    = 1'b0;
      bus.mask_wdata = '0;
      repeat (3) @(negedge clk);
      check_val("reset_int_signal_n", 16'(bus.int_signal_n), 16'h1);
      check_val("reset_mask", mask, 16'h00FF);
      check_val("reset_pending", 16'(pending), 16'h0);
      check_val("reset_busy", 16'(busy), 16'h0);
      check_val("reset_index", 16'(bus.int_index), 16'h0);
      rst = 1'b1;

      // 1: single pulse latency
      @(negedge clk) irq_raw[3] = 1'b1;
      @(negedge clk) irq_raw[3] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("s1_pending", 16'(pending), 16'h0008);
      check_val("s1_no_req_yet", 16'(bus.int_signal_n), 16'h1);
      @(negedge clk);
      check_val("s1_req", 16'(bus.int_signal_n), 16'h0);
      check_val("s1_index", 16'(bus.int_index), 16'h3);
      pulse_taken();
      check_val("s1_cleared", 16'(pending), 16'h0);
      check_val("s1_busy_service", 16'(busy), 16'h1);
      pulse_eret();
      check_val("s1_idle", 16'(busy), 16'h0);

      // 2: simultaneous arrivals, priority order
      @(negedge clk) irq_raw = 8'h24;
      @(negedge clk) irq_raw = 8'h00;
      wait_req("s2_first", 2);
      service_one();
      wait_req("s2_second", 5);
      service_one();
      check_val("s2_pending_end", 16'(pending), 16'h0);

      // 3: masked source stays pending, unmasking releases it
      write_mask(16'h00FB);
      pulse_raw(2);
      repeat (5) @(negedge clk);
      check_val("s3_pending", 16'(pending), 16'h0004);
      check_val("s3_no_req", 16'(bus.int_signal_n), 16'h1);
      write_mask(16'h00FF);
      wait_req("s3_unmasked", 2);
      service_one();

      // 4: no preemption by a higher-priority arrival
      pulse_raw(4);
      wait_req("s4_first", 4);
      pulse_raw(0);
      repeat (5) @(negedge clk);
      check_val("s4_held_index", 16'(bus.int_index), 16'h4);
      check_val("s4_held_req", 16'(bus.int_signal_n), 16'h0);
      service_one();
      wait_req("s4_second", 0);
      service_one();

      // 5: held level gives one event; edge coinciding with taken is retained
      req_before = n_req;
      @(negedge clk) irq_raw[1] = 1'b1;
      repeat (20) @(negedge clk);
      check_val("s5_one_request", 16'(n_req - req_before), 16'h1);
      irq_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      irq_raw[1] = 1'b1;
      @(negedge clk) irq_raw[1] = 1'b0;
      @(negedge clk) bus.taken_n = 1'b0;
      @(negedge clk) bus.taken_n = 1'b1;
      check_val("s5_set_wins", 16'(pending[1]), 16'h1);
      check_val("s5_service", 16'(bus.int_signal_n), 16'h1);
      pulse_eret();
      wait_req("s5_again", 1);
      service_one();

      // 6: asynchronous reset in REQ and in SERVICE, stray strobes in IDLE
      pulse_raw(6);
      wait_req("s6_req", 6);
      #2 rst = 1'b0;
      #1;
      check_val("s6_rst_req_sig", 16'(bus.int_signal_n), 16'h1);
      check_val("s6_rst_req_busy", 16'(busy), 16'h0);
      @(negedge clk) rst = 1'b1;
      pulse_raw(6);
      wait_req("s6_req2", 6);
      pulse_taken();
      pulse_raw(7);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("s6_rst_srv_busy", 16'(busy), 16'h0);
      check_val("s6_rst_srv_pending", 16'(pending), 16'h0);
      check_val("s6_rst_srv_sig", 16'(bus.int_signal_n), 16'h1);
      @(negedge clk) rst = 1'b1;
      pulse_taken();
      pulse_eret();
      check_val("s6_stray_busy", 16'(busy), 16'h0);
      check_val("s6_stray_sig", 16'(bus.int_signal_n), 16'h1);

      // random phase
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         irq_raw     = irq_raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
         bus.taken_n = ($urandom_range(0, 3) != 0);
         bus.eret_n  = ($urandom_range(0, 3) != 0);
         bus.mask_we = ($urandom_range(0, 19) == 0);
         bus.mask_wdata = 16'($urandom | $urandom);
      end
      @(negedge clk) begin
         irq_raw     = '0;
         bus.taken_n = 1'b1;
         bus.eret_n  = 1'b1;
         bus.mask_we = 1'b0;
      end
      repeat (10) @(negedge clk);
      check_val("leftover_expected", 16'(exp_q.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
